rr_stream_arbiter: RTL and testbench

- Shares one registered valid/ready output stage between NUM_REQ upstream streams using round-robin arbitration.
- Provides one-cycle registered latency and full throughput of one beat per cycle.
- Sits in front of a downstream pipeline stage that has a single consumer. It merges several producers into that stage and tags each beat with the index of the producer that sent it.

---
 rtl/rr_stream_arbiter.sv | 92 +++++++++
 tb/tb_rr_stream_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered output stage, tagged with source index.
// Optional burst locking (hold grant until in_last) is enabled by defining RR_ARB_BURST_LOCK_EN.
module rr_stream_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready
);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lanes;
  logic [SRC_W-1:0]                   ptr;
  logic [SRC_W-1:0]                   win;
  logic [SRC_W-1:0]                   idx;
  logic                               any;
  logic                               load_en;

  assign lanes   = in_data;
  assign load_en = !out_valid || out_ready;

`ifdef RR_ARB_BURST_LOCK_EN
  logic             lock;
  logic [SRC_W-1:0] lock_src;
`endif

  // Scan from the slot after the last grant so the previous winner ends up lowest priority.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && in_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
`ifdef RR_ARB_BURST_LOCK_EN
    // A locked burst owns the stage; a gap in its valid becomes a bubble.
    if (lock) begin
      win = lock_src;
      any = in_valid[lock_src];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (any && load_en && !reset) in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      ptr       <= SRC_W'(NUM_REQ - 1);
    end else if (load_en) begin
      out_valid <= any;
      if (any) begin
        out_data <= lanes[win];
        out_last <= in_last[win];
        out_src  <= win;
        ptr      <= win;
      end
    end
  end

`ifdef RR_ARB_BURST_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock     <= 1'b0;
      lock_src <= '0;
    end else if (load_en && any) begin
      lock     <= !in_last[win];
      lock_src <= win;
    end
  end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench for rr_stream_arbiter: stimulus pushes hand-computed beats, a negedge monitor pops and compares.
module tb_rr_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0][DW-1:0] lanes;
  logic [N-1:0]      in_valid, in_last, in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_last, out_ready;
  logic [1:0]        out_src;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  rr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_data(lanes), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void exp_push(input int s, input int d, input bit l);
    beat_t b;
    b.src  = 2'(s);
    b.data = DW'(d);
    b.last = l;
    exp_q.push_back(b);
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat is consumed at the next edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beat_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got src=%0d data=0x%0h, expected none", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_src !== e.src || out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL beat: got src=%0d data=0x%0h last=%0b expected src=%0d data=0x%0h last=%0b",
                   out_src, out_data, out_last, e.src, e.data, e.last);
        end
      end
    end
  end

  initial begin
    int b1;
    logic acc;
    reset     = 1'b1;
    lanes     = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;

    // Reset held with every requester valid
    repeat (2) begin
      @(posedge clk);
      #4;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Rotation 0,1,2,3,0
    exp_push(0, 'h11, 1); exp_push(1, 'h22, 1); exp_push(2, 'h33, 1);
    exp_push(3, 'h44, 1); exp_push(0, 'h11, 1);
    repeat (5) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Stall holding src 1, then release goes to src 2
    step(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 'h22);
      chk("stall_src", out_src, 1);
      chk("stall_in_ready", in_ready, 0);
      if (i < 2) step(4'b1111, 1'b0);
    end
    exp_push(1, 'h22, 1); exp_push(2, 'h33, 1);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Sparse 3/0 with wrap, then a dropped requester is skipped
    exp_push(3, 'h44, 1);
    step(4'b1000, 1'b1);
    exp_push(0, 'h11, 1); exp_push(3, 'h44, 1); exp_push(0, 'h11, 1);
    repeat (3) step(4'b1001, 1'b1);
    exp_push(1, 'h22, 1); exp_push(3, 'h44, 1);
    step(4'b1110, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b0000, 1'b1);

    // Single requester at full throughput
    for (int i = 0; i < 6; i++) begin
      lanes[2] = 8'hA0 + 8'(i);
      exp_push(2, 'hA0 + i, 1);
      step(4'b0100, 1'b1);
      #3;
      chk("thru_valid", out_valid, 1);
    end
    step(4'b0000, 1'b1);
    lanes[2] = 8'h33;

    // Burst from src 1 (last=0,0,1) with a one-cycle gap, src 2 valid throughout
`ifdef RR_ARB_BURST_LOCK_EN
    exp_push(1, 'h61, 0); exp_push(1, 'h62, 0); exp_push(1, 'h63, 1); exp_push(2, 'h33, 1);
`else
    exp_push(1, 'h61, 0); exp_push(2, 'h33, 1); exp_push(1, 'h62, 0);
    exp_push(2, 'h33, 1); exp_push(1, 'h63, 1);
`endif
    b1 = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid  = {1'b0, 1'b1, (b1 < 3 && c != 1), 1'b0};
      in_last   = {1'b1, 1'b1, (b1 == 2), 1'b1};
      lanes[1]  = 8'h61 + 8'(b1);
      out_ready = 1'b1;
      #3;
`ifdef RR_ARB_BURST_LOCK_EN
      if (c == 2) chk("burst_bubble", out_valid, 0);
`endif
      acc = in_ready[1];
      @(posedge clk);
      #1;
      if (acc) b1++;
    end
    in_last = 4'b1111;
    lanes   = {8'h44, 8'h33, 8'h22, 8'h11};
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Asynchronous reset discards a held beat
    step(4'b0001, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_push(0, 'h11, 1);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
